// File: rtl/mem_arbiter_if.sv
// Bundles the IFU/LSU request-response channels and the data-memory port of mem_arbiter.
// slave: arbiter view. master: requester/memory view.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [63:0] ifu_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_wen;
  logic [3:0]  lsu_size;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [63:0] lsu_rdata;
  logic        lsu_err;

  logic        mem_ena;
  logic        mem_wen;
  logic [3:0]  mem_mask;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_wen, lsu_size, lsu_addr, lsu_wdata, lsu_resp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    output mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_wen, lsu_size, lsu_addr, lsu_wdata, lsu_resp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
    input  mem_ena, mem_wen, mem_mask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between IFU and LSU with programmable access latency.
// One transaction in flight: IDLE -> WAIT (LATENCY cycles) -> ACCESS (1 cycle) -> RESP.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_ifu_q, grant_ifu_d;  // also serves as the last-grant record
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  size_q, size_d;
  logic        err_q, err_d;
  logic [63:0] ifu_rdata_q, ifu_rdata_d;
  logic [63:0] lsu_rdata_q, lsu_rdata_d;

  logic        ifu_win, lsu_win;
  logic        req_misaligned;
  logic        resp_ready;
  logic        in_access, in_resp;
  logic [63:0] rdata_masked;

  // Invalid (non one-hot) sizes count as misaligned.
  function automatic logic is_misaligned(input logic [3:0] size, input logic [2:0] lsb);
    case (size)
      4'b0001: return lsb != 3'd0;
      4'b0010: return lsb[1:0] != 2'd0;
      4'b0100: return lsb[0];
      4'b1000: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [3:0] size);
    case (size)
      4'b0001: return 64'hffff_ffff_ffff_ffff;
      4'b0010: return 64'h0000_0000_ffff_ffff;
      4'b0100: return 64'h0000_0000_0000_ffff;
      4'b1000: return 64'h0000_0000_0000_00ff;
      default: return 64'h0;
    endcase
  endfunction

  // Arbitration: only the winner sees ready, and only in IDLE.
  always_comb begin
    lsu_win = 1'b0;
    ifu_win = 1'b0;
    if (state_q == StIdle) begin
`ifdef MEM_ARB_RR_EN
      if (bus.lsu_req_valid && bus.ifu_req_valid) begin
        ifu_win = ~grant_ifu_q;
        lsu_win = grant_ifu_q;
      end else begin
        lsu_win = bus.lsu_req_valid;
        ifu_win = bus.ifu_req_valid;
      end
`else
      lsu_win = bus.lsu_req_valid;
      ifu_win = bus.ifu_req_valid & ~bus.lsu_req_valid;
`endif
    end
  end

  assign bus.lsu_req_ready = lsu_win;
  assign bus.ifu_req_ready = ifu_win;

  assign req_misaligned = lsu_win ? is_misaligned(bus.lsu_size, bus.lsu_addr[2:0])
                                  : (bus.ifu_addr[1:0] != 2'b00);
  assign resp_ready     = grant_ifu_q ? bus.ifu_resp_ready : bus.lsu_resp_ready;
  assign rdata_masked   = wen_q ? 64'h0 : (bus.mem_rdata & size_mask(size_q));

  // Next-state and latch logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_ifu_d = grant_ifu_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    size_d      = size_q;
    err_d       = err_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_win || ifu_win) begin
          grant_ifu_d = ifu_win;
          addr_d      = lsu_win ? bus.lsu_addr : bus.ifu_addr;
          wdata_d     = lsu_win ? bus.lsu_wdata : 64'h0;
          wen_d       = lsu_win & bus.lsu_wen;
          size_d      = lsu_win ? bus.lsu_size : 4'b0010;
          err_d       = req_misaligned;
          // Misaligned requests answer with zero data, so clear it up front.
          if (ifu_win) ifu_rdata_d = 64'h0;
          else         lsu_rdata_d = 64'h0;
          if (req_misaligned) begin
            state_d = StResp;
          end else if (LATENCY == 0) begin
            state_d = StAccess;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAccess: begin
        if (grant_ifu_q) ifu_rdata_d = rdata_masked;
        else             lsu_rdata_d = rdata_masked;
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      grant_ifu_q <= 1'b0;
      addr_q      <= 64'h0;
      wdata_q     <= 64'h0;
      wen_q       <= 1'b0;
      size_q      <= 4'h0;
      err_q       <= 1'b0;
      ifu_rdata_q <= 64'h0;
      lsu_rdata_q <= 64'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_ifu_q <= grant_ifu_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      size_q      <= size_d;
      err_q       <= err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  // Outputs decode from current state; a store in ACCESS still commits on a reset edge.
  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  assign bus.ifu_resp_valid = in_resp & grant_ifu_q;
  assign bus.lsu_resp_valid = in_resp & ~grant_ifu_q;
  assign bus.lsu_err        = in_resp & ~grant_ifu_q & err_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.lsu_rdata      = lsu_rdata_q;

  assign bus.mem_ena   = in_access;
  assign bus.mem_wen   = in_access & wen_q;
  assign bus.mem_mask  = in_access ? size_q : 4'h0;
  assign bus.mem_addr  = in_access ? addr_q : 64'h0;
  assign bus.mem_wdata = in_access ? wdata_q : 64'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard and a byte-addressed little-endian memory model.
module tb_mem_arbiter;
  localparam int unsigned Lat = 2;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(Lat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: low 10 address bits select a byte.
  logic [7:0]  mem_arr [0:1023];
  logic        mem_init_done = 1'b0;
  int unsigned cyc_cnt = 0;
  int unsigned ena_cnt = 0;
  int unsigned ena_cyc = 0;
  logic        last_wen = 1'b0;
  logic [3:0]  last_mask = 4'h0;

  function automatic int nbytes(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  always_comb begin
    bus.mem_rdata = 64'h0;
    if (bus.mem_ena && !bus.mem_wen)
      for (int i = 0; i < 8; i++)
        if (i < nbytes(bus.mem_mask))
          bus.mem_rdata[8*i +: 8] = mem_arr[10'(bus.mem_addr[9:0] + 10'(i))];
  end

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= 8'h00;
      mem_arr[10'h000] <= 8'h13;
      mem_arr[10'h001] <= 8'h04;
      mem_arr[10'h200] <= 8'h44;
      mem_arr[10'h201] <= 8'h33;
      mem_arr[10'h202] <= 8'h22;
      mem_arr[10'h203] <= 8'h11;
      mem_init_done <= 1'b1;
    end else if (bus.mem_ena) begin
      ena_cnt   <= ena_cnt + 1;
      ena_cyc   <= cyc_cnt;
      last_wen  <= bus.mem_wen;
      last_mask <= bus.mem_mask;
      if (bus.mem_wen)
        for (int i = 0; i < 8; i++)
          if (i < nbytes(bus.mem_mask))
            mem_arr[10'(bus.mem_addr[9:0] + 10'(i))] <= bus.mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic        is_lsu;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_lsu;
    logic        wen;
    logic [3:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    logic        ena;
  } vec_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned resp_seen = 0;
  int unsigned resp_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ifu_resp_valid"}, 64'(bus.ifu_resp_valid), 64'd0);
    check({tag, " lsu_resp_valid"}, 64'(bus.lsu_resp_valid), 64'd0);
    check({tag, " lsu_err"}, 64'(bus.lsu_err), 64'd0);
    check({tag, " ifu_rdata"}, bus.ifu_rdata, 64'd0);
    check({tag, " lsu_rdata"}, bus.lsu_rdata, 64'd0);
    check({tag, " mem_ena"}, 64'(bus.mem_ena), 64'd0);
    check({tag, " mem_wen"}, 64'(bus.mem_wen), 64'd0);
    check({tag, " mem_mask"}, 64'(bus.mem_mask), 64'd0);
    check({tag, " mem_addr"}, bus.mem_addr, 64'd0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 64'd0);
  endtask

  // Called at the falling edge: pops the scoreboard on every response handshake.
  task automatic check_resp();
    exp_t e;
    if (!bus.mem_ena)
      check("mem outputs idle", 64'(bus.mem_wen | (|bus.mem_mask) | (|bus.mem_addr)
                                    | (|bus.mem_wdata)), 64'd0);
    check("one resp_valid", 64'(bus.ifu_resp_valid & bus.lsu_resp_valid), 64'd0);
    if ((bus.ifu_resp_valid && bus.ifu_resp_ready) ||
        (bus.lsu_resp_valid && bus.lsu_resp_ready)) begin
      resp_seen++;
      resp_cyc = cyc_cnt;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected response: got lsu_resp=%0b ifu_resp=%0b expected none",
                 bus.lsu_resp_valid, bus.ifu_resp_valid);
      end else begin
        e = sb_q.pop_front();
        check("resp source", 64'(bus.lsu_resp_valid), 64'(e.is_lsu));
        check("resp rdata", e.is_lsu ? bus.lsu_rdata : bus.ifu_rdata, e.rdata);
        if (e.is_lsu) check("lsu_err", 64'(bus.lsu_err), 64'(e.err));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_resp();
    @(posedge clk);
    #1;
  endtask

  // Raises a request and returns one cycle after its handshake edge.
  task automatic do_req(input logic is_lsu, input logic wen, input logic [3:0] size,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output int unsigned hs_cyc);
    logic done;
    done   = 1'b0;
    hs_cyc = 0;
    if (is_lsu) begin
      bus.lsu_req_valid = 1'b1;
      bus.lsu_wen       = wen;
      bus.lsu_size      = size;
      bus.lsu_addr      = addr;
      bus.lsu_wdata     = wdata;
    end else begin
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = addr;
    end
    #1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (is_lsu ? bus.lsu_req_ready : bus.ifu_req_ready) begin
        hs_cyc = cyc_cnt;
        done   = 1'b1;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout: got no ready expected ready (lsu=%0b)", is_lsu);
    end
    // Changing the request fields after acceptance must have no effect.
    if (is_lsu) begin
      bus.lsu_req_valid = 1'b0;
      bus.lsu_addr      = '1;
      bus.lsu_wdata     = '1;
      bus.lsu_size      = 4'h0;
    end else begin
      bus.ifu_req_valid = 1'b0;
      bus.ifu_addr      = '1;
    end
  endtask

  task automatic wait_resp(input int unsigned seen0);
    for (int n = 0; n < 60 && resp_seen == seen0; n++) tick();
    if (resp_seen == seen0) begin
      checks++;
      errors++;
      $display("FAIL response timeout: got %0d responses expected %0d", resp_seen, seen0 + 1);
    end
  endtask

  vec_t vecs[16];

  initial begin
    int unsigned hs, seen0, seen1, ena0;
    exp_t        e;
    logic        got;
    logic [3:0]  exp_who;

    vecs[0]  = '{1'b0, 1'b0, 4'b0010, 64'h8000_0000, 64'h0, 64'h413, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 4'b1000, 64'h8000_0103, 64'hAB, 64'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 4'b0001, 64'h8000_0100, 64'h0, 64'hAB00_0000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 4'b0010, 64'h8000_0102, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'b0100, 64'h8000_0103, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'b0010, 64'h8000_0200, 64'h0, 64'h1122_3344, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 4'b0100, 64'h8000_0202, 64'h0, 64'h1122, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'b1000, 64'h8000_0201, 64'h0, 64'h33, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'b0011, 64'h8000_0000, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'b0000, 64'h8000_0000, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'b0010, 64'h8000_0002, 64'h0, 64'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'b0001, 64'h8000_0300, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0,
                 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'b0001, 64'h8000_0304, '1, 64'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'b0001, 64'h8000_0300, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0,
                 1'b1};
    vecs[14] = '{1'b1, 1'b0, 4'b0010, 64'h8000_0304, 64'h0, 64'h0123_4567, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 4'b0010, 64'h8000_0304, 64'h0, 64'h0123_4567, 1'b0, 1'b1};

    rst                = 1'b1;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = 64'h0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_size       = 4'h0;
    bus.lsu_addr       = 64'h0;
    bus.lsu_wdata      = 64'h0;
    bus.lsu_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

`ifdef MEM_ARB_RR_EN
    // Round robin: both requesters held valid; IFU wins the first conflict after reset.
    exp_who           = 4'b1010;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 64'h8000_0000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_size      = 4'b0010;
    bus.lsu_addr      = 64'h8000_0200;
    #1;
    for (int k = 0; k < 4; k++) begin
      got   = 1'b0;
      seen0 = resp_seen;
      for (int n = 0; n < 40 && !got; n++) begin
        if (bus.ifu_req_ready || bus.lsu_req_ready) begin
          got = 1'b1;
          check("rr grant is lsu", 64'(bus.lsu_req_ready), 64'(exp_who[k]));
          check("rr single ready", 64'(bus.lsu_req_ready & bus.ifu_req_ready), 64'd0);
          e = '{exp_who[k], exp_who[k] ? 64'h1122_3344 : 64'h413, 1'b0};
          sb_q.push_back(e);
        end
        tick();
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL rr grant timeout: got no ready expected grant %0d", k);
      end
      wait_resp(seen0);
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    tick();
`endif

    // Table of single transactions.
    for (int i = 0; i < 16; i++) begin
      e = '{vecs[i].is_lsu, vecs[i].rdata, vecs[i].err};
      sb_q.push_back(e);
      seen0 = resp_seen;
      ena0  = ena_cnt;
      do_req(vecs[i].is_lsu, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata, hs);
      wait_resp(seen0);
      check($sformatf("vec%0d ena pulses", i), 64'(ena_cnt - ena0), 64'(vecs[i].ena));
      if (vecs[i].ena) begin
        check($sformatf("vec%0d ena latency", i), 64'(ena_cyc - hs), 64'(Lat + 1));
        check($sformatf("vec%0d mem_wen", i), 64'(last_wen), 64'(vecs[i].wen));
        check($sformatf("vec%0d mem_mask", i), 64'(last_mask),
              64'(vecs[i].is_lsu ? vecs[i].size : 4'b0010));
        check($sformatf("vec%0d resp latency", i), 64'(resp_cyc - hs), 64'(Lat + 2));
      end else begin
        check($sformatf("vec%0d resp latency", i), 64'(resp_cyc - hs), 64'd1);
      end
      tick();
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority conflict: LSU first, IFU in the IDLE cycle after the LSU response.
    e = '{1'b1, 64'h1122_3344, 1'b0};
    sb_q.push_back(e);
    e = '{1'b0, 64'h413, 1'b0};
    sb_q.push_back(e);
    seen0             = resp_seen;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_addr      = 64'h8000_0000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_wen       = 1'b0;
    bus.lsu_size      = 4'b0010;
    bus.lsu_addr      = 64'h8000_0200;
    #1;
    check("conflict lsu ready", 64'(bus.lsu_req_ready), 64'd1);
    check("conflict ifu ready", 64'(bus.ifu_req_ready), 64'd0);
    tick();
    bus.lsu_req_valid = 1'b0;
    #1;
    got = 1'b0;
    hs  = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (bus.ifu_req_ready) begin
        got = 1'b1;
        hs  = cyc_cnt;
      end
      tick();
    end
    bus.ifu_req_valid = 1'b0;
    check("conflict ifu granted", 64'(got), 64'd1);
    check("conflict ifu after lsu resp", 64'(hs), 64'(resp_cyc + 1));
    wait_resp(seen0 + 1);
    tick();
`endif

    // Response held while resp_ready is low; no acceptance in the response handshake cycle.
    bus.lsu_resp_ready = 1'b0;
    e = '{1'b1, 64'h1122_3344, 1'b0};
    sb_q.push_back(e);
    do_req(1'b1, 1'b0, 4'b0010, 64'h8000_0200, 64'h0, hs);
    for (int n = 0; n < 20 && !bus.lsu_resp_valid; n++) tick();
    for (int k = 0; k < 5; k++) begin
      check("held resp_valid", 64'(bus.lsu_resp_valid), 64'd1);
      check("held rdata", bus.lsu_rdata, 64'h1122_3344);
      check("held err", 64'(bus.lsu_err), 64'd0);
      tick();
    end
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_addr       = 64'h8000_0000;
    bus.lsu_resp_ready = 1'b1;
    #1;
    check("no accept during resp", 64'(bus.ifu_req_ready), 64'd0);
    e = '{1'b0, 64'h413, 1'b0};
    sb_q.push_back(e);
    seen1 = resp_seen;
    do_req(1'b0, 1'b0, 4'b0010, 64'h8000_0000, 64'h0, hs);
    check("ifu accepted after resp", 64'(hs), 64'(resp_cyc + 1));
    wait_resp(seen1 + 1);
    tick();

    // Reset during WAIT suppresses the store.
    ena0 = ena_cnt;
    do_req(1'b1, 1'b1, 4'b0010, 64'h8000_0200, 64'hDEAD_BEEF, hs);
    rst = 1'b1;
    tick();
    check_all_zero("rst in wait");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("store suppressed by rst", 64'(ena_cnt - ena0), 64'd0);
    e = '{1'b1, 64'h1122_3344, 1'b0};
    sb_q.push_back(e);
    seen0 = resp_seen;
    do_req(1'b1, 1'b0, 4'b0010, 64'h8000_0200, 64'h0, hs);
    wait_resp(seen0);
    tick();

    // Reset at the edge closing ACCESS still commits the store.
    ena0 = ena_cnt;
    do_req(1'b1, 1'b1, 4'b0010, 64'h8000_0300, 64'h5566_7788, hs);
    for (int k = 0; k < Lat; k++) tick();
    check("store in access", 64'(bus.mem_ena), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("store commits at rst", 64'(ena_cnt - ena0), 64'd1);
    check_all_zero("rst in access");
    tick();
    e = '{1'b1, 64'h5566_7788, 1'b0};
    sb_q.push_back(e);
    seen0 = resp_seen;
    do_req(1'b1, 1'b0, 4'b0010, 64'h8000_0300, 64'h0, hs);
    wait_resp(seen0);
    tick();

    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory (DPI-backed, combinational read, write on posedge when enabled) between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time over valid/ready handshakes and inserts a programmable access delay to emulate memory latency.
- Drives exactly one memory-enable cycle per transaction, registers the read data, and returns it on a per-requester response channel.

Parameters:
LATENCY, 2, wait cycles between request acceptance and the memory access cycle (0..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  64  fetch address; always a 4-byte access
ifu_resp_valid  out  1  fetch data valid
ifu_resp_ready  in  1  IFU consumes response
ifu_rdata  out  64  fetched word, right-aligned
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1=store, 0=load
lsu_size  in  4  one-hot size: bit0=8B, bit1=4B, bit2=2B, bit3=1B
lsu_addr  in  64  byte address
lsu_wdata  in  64  store data
lsu_resp_valid  out  1  load data or store completion valid
lsu_resp_ready  in  1  LSU consumes response
lsu_rdata  out  64  load data, right-aligned, zero-extended
lsu_err  out  1  misaligned access flag, qualified by lsu_resp_valid
mem_ena  out  1  memory enable
mem_wen  out  1  memory write enable
mem_mask  out  4  size, same one-hot encoding as lsu_size
mem_addr  out  64  memory address
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, combinational, right-aligned

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP.
- Reset values:
  - State is IDLE, wait counter is 0, grant is LSU.
  - All *_resp_valid, lsu_err, *_rdata and mem_* outputs are 0.
- IDLE:
  - req_ready is asserted only to the arbitration winner; ready is combinational on valids and state.
  - Fixed priority: LSU wins over IFU when both are valid.
  - On handshake, latch grant, addr, wen (IFU: 0), size (IFU: 4'b0010) and wdata (IFU: 0).
  - Next state is WAIT with counter=LATENCY-1. If LATENCY==0, next state is ACCESS.
- WAIT:
  - Counter decrements each cycle; at 0, next state is ACCESS.
  - mem_ena=0.
- ACCESS (exactly one cycle):
  - mem_ena=1, and mem_wen/mem_mask/mem_addr/mem_wdata come from the latched values.
  - The store commits at the closing edge.
  - mem_rdata is registered into the granted requester's rdata at the same edge; loads only, stores register 0.
  - Next state is RESP.
- RESP:
  - The granted requester's resp_valid=1; rdata is held stable.
  - On resp_ready, next state is IDLE. No new request is accepted in the same cycle as the response handshake.
- Outside ACCESS, all mem_* outputs are 0.
- Timing:
  - Minimum transaction length with LATENCY=0 and resp_ready held high is 3 cycles (IDLE, ACCESS, RESP).
  - With LATENCY=N it is N+3 cycles.
- Misalignment:
  - An LSU request whose addr is not a multiple of its size is still accepted, but skips WAIT and ACCESS (mem_ena never asserted).
  - Next state is RESP with lsu_err=1 and lsu_rdata=0.
  - IFU addr[1:0]!=0 is treated the same way, with no err port; ifu_rdata=0.
- An invalid lsu_size (not one-hot, including 0) is treated as misaligned.
- Requests are never dropped: the loser keeps valid asserted and is served after the winner's RESP handshake.
- Reset:
  - rst takes priority in every state; next state is IDLE and responses are cleared.
  - A store is suppressed if rst arrives in IDLE or WAIT.
  - A store in ACCESS at the reset edge still commits, because mem_ena is decoded from current state.
- Requesters may change addr/wdata after handshake without effect.

Optional Feature:
- Macro MEM_ARB_RR_EN, enabled: round-robin arbitration.
  - When both requesters are valid in IDLE, the one not granted last wins.
  - The last-grant register resets to LSU, so IFU wins the first conflict after reset.
  - A single valid requester always wins.
- Macro absent: fixed LSU-over-IFU priority.
  - IFU can be starved while lsu_req_valid stays high.

Test Plan:
- LATENCY=2, IFU fetch from 0x80000000; memory returns 0x00000413 -> mem_ena high exactly 1 cycle, 3 cycles after the handshake; ifu_resp_valid with ifu_rdata=0x413.
- LSU store with size=4'b1000 to 0x80000103, wdata=0xAB, then an 8B load from 0x80000100 -> exactly one mem_ena pulse with mem_wen=1 and mem_mask=4'b1000 for the store; load returns the byte 0xAB in bits [31:24].
- IFU and LSU valid in the same cycle (fixed priority) -> LSU granted first, IFU granted in the IDLE cycle after the LSU response handshake; IFU valid held throughout.
- LSU 4B load from 0x80000102 -> no mem_ena pulse; lsu_resp_valid with lsu_err=1 and lsu_rdata=0, one cycle after the handshake.
- rst during WAIT of a store to 0x80000200 -> no mem_ena; a later read of 0x80000200 returns the old value; all outputs are 0 after the reset edge.
- With MEM_ARB_RR_EN, both requesters continuously valid for 4 transactions -> grants in order IFU, LSU, IFU, LSU; with resp_ready held low 5 cycles -> resp_valid and rdata held stable.
